// File: rtl/instruction_loader.sv
// Boot-time program loader: takes a length-prefixed little-endian byte stream, packs it
// into instructions and writes them to consecutive addresses while holding the CPU in reset.
module instruction_loader #(
  parameter int unsigned       XLEN               = 64,
  parameter int unsigned       INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0]   BASE_ADDR          = '0,
  parameter int unsigned       MAX_WORDS          = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          cpu_rst_hold,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   words_written
);

  localparam int unsigned     BPW   = INSTRUCTION_LENGTH / 8;
  localparam int unsigned     CNT_W = (BPW > 4) ? $clog2(BPW) : 2;
  localparam logic [XLEN-1:0] BPW_X = XLEN'(BPW);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  // Handshake: a byte moves on a rising clk edge where in_valid & in_ready are both high;
  // in_ready depends on state only, so the source may hold in_valid/in_data for any time.
  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]                   count_q, count_d;
  logic [INSTRUCTION_LENGTH-1:0] word_q, word_d;
  logic [31:0]                   words_written_q, words_written_d;
  logic                          dbg_wr_en_q, dbg_wr_en_d;
  logic [XLEN-1:0]               dbg_addr_q, dbg_addr_d;
  logic [INSTRUCTION_LENGTH-1:0] dbg_instr_q, dbg_instr_d;
  logic                          xfer;

  assign in_ready = (state_q == S_LEN) || (state_q == S_DATA);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    count_d         = count_q;
    word_d          = word_q;
    words_written_d = words_written_q;
    dbg_wr_en_d     = 1'b0;
    dbg_addr_d      = dbg_addr_q;
    dbg_instr_d     = dbg_instr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d         = S_LEN;
          byte_cnt_d      = '0;
          count_d         = '0;
          words_written_d = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          count_d    = {in_data, count_q[31:8]};
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == CNT_W'(3)) begin
            byte_cnt_d = '0;
            if (count_d == 32'd0)                  state_d = S_DONE;
            else if (count_d > 32'(MAX_WORDS))     state_d = S_ERR;
            else                                   state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          for (int k = 0; k < BPW; k++) begin
            if (byte_cnt_q == CNT_W'(k)) word_d[8*k +: 8] = in_data;
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          // The strobe is registered so it appears in the WRITE cycle itself.
          if (byte_cnt_q == CNT_W'(BPW - 1)) begin
            byte_cnt_d  = '0;
            state_d     = S_WRITE;
            dbg_wr_en_d = 1'b1;
            dbg_addr_d  = BASE_ADDR + XLEN'(words_written_q) * BPW_X;
            dbg_instr_d = word_d;
          end
        end
      end
      S_WRITE: begin
        words_written_d = words_written_q + 32'd1;
        state_d         = (words_written_d == count_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      byte_cnt_q      <= '0;
      count_q         <= '0;
      word_q          <= '0;
      words_written_q <= '0;
      dbg_wr_en_q     <= 1'b0;
      dbg_addr_q      <= '0;
      dbg_instr_q     <= '0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      count_q         <= count_d;
      word_q          <= word_d;
      words_written_q <= words_written_d;
      dbg_wr_en_q     <= dbg_wr_en_d;
      dbg_addr_q      <= dbg_addr_d;
      dbg_instr_q     <= dbg_instr_d;
    end
  end

  assign dbg_wr_en     = dbg_wr_en_q;
  assign dbg_addr      = dbg_addr_q;
  assign dbg_instr     = dbg_instr_q;
  assign words_written = words_written_q;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign cpu_rst_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: randomized image loads, scoreboarded write strobes
// (address, data, cycle) against a word-list model of the stream format.
module tb_instruction_loader;

  localparam int XLEN = 64;
  localparam int IL   = 32;
  localparam int BPW  = IL / 8;
  localparam int MAXW = 1024;
  localparam logic [XLEN-1:0] BASE = '0;

  logic            clk = 1'b0;
  logic            rst, start, in_valid;
  logic [7:0]      in_data;
  logic            in_ready, dbg_wr_en, cpu_rst_hold, done, error;
  logic [XLEN-1:0] dbg_addr;
  logic [IL-1:0]   dbg_instr;
  logic [31:0]     words_written;

  instruction_loader #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .cpu_rst_hold(cpu_rst_hold), .done(done), .error(error), .words_written(words_written)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [IL-1:0]   exp_q[$];
  logic [XLEN-1:0] exp_addr_q[$];
  int unsigned     exp_cyc_q[$];
  logic [IL-1:0]   img[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (dbg_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0h instr %0h, expected no write", dbg_addr, dbg_instr);
      end else begin
        check("strobe_addr", dbg_addr, exp_addr_q.pop_front());
        check("strobe_instr", 64'(dbg_instr), 64'(exp_q.pop_front()));
        check("strobe_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        check("ready_low_on_strobe", 64'(in_ready), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int unsigned acc);
    int w;
    w = 0;
    acc = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      w++;
      if (w > 40) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: got in_ready=0 for 40 cycles, expected 1");
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold_after_start", 64'(cpu_rst_hold), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
    check("error_after_start", 64'(error), 64'd0);
    check("ww_after_start", 64'(words_written), 64'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(dbg_wr_en), 64'd0);
    check("rst_addr", dbg_addr, 64'd0);
    check("rst_instr", 64'(dbg_instr), 64'd0);
    check("rst_hold", 64'(cpu_rst_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ww", 64'(words_written), 64'd0);
  endtask

  // Loads n words of img. abort_at >= 0 applies rst instead of sending that data byte.
  task automatic do_load(input int n, input bit gaps, input bit start_mid, input int abort_at);
    int unsigned acc, prev_acc;
    int t;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gaps, acc);
    if (n > MAXW) begin
      in_valid = 1'b0;
      @(negedge clk);
      check("err_error", 64'(error), 64'd1);
      check("err_hold", 64'(cpu_rst_hold), 64'd1);
      check("err_in_ready", 64'(in_ready), 64'd0);
      check("err_done", 64'(done), 64'd0);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (6) begin
        @(negedge clk);
        check("err_stray_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    prev_acc = 0;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < BPW; k++) begin
        if (abort_at == w * BPW + k) begin
          in_valid = 1'b0;
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          check_reset_vals();
          return;
        end
        if (start_mid && w == 0 && k == 1) start = 1'b1;
        send_byte(img[w][8*k +: 8], gaps, acc);
        start = 1'b0;
        if (k == BPW - 1) begin
          exp_q.push_back(img[w]);
          exp_addr_q.push_back(BASE + XLEN'(w * BPW));
          exp_cyc_q.push_back(acc + 1);
          if (!gaps && w > 0) check("word_spacing", 64'(acc - prev_acc), 64'(BPW + 1));
          prev_acc = acc;
        end
      end
    end
    in_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("load_done", 64'(done), 64'd1);
    check("load_hold", 64'(cpu_rst_hold), 64'd0);
    check("load_error", 64'(error), 64'd0);
    check("load_ww", 64'(words_written), 64'(n));
    if (n > 0) begin
      check("hold_addr", dbg_addr, BASE + XLEN'((n - 1) * BPW));
      check("hold_instr", 64'(dbg_instr), 64'(img[n-1]));
    end
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(IL'($urandom));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals();

    img = '{32'h00000013};
    do_load(1, 1'b0, 1'b0, -1);

    img = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    do_load(3, 1'b0, 1'b0, -1);

    rand_img(8);
    do_load(8, 1'b1, 1'b0, -1);
    do_load(8, 1'b0, 1'b0, -1);

    do_load(0, 1'b0, 1'b0, -1);
    do_load(MAXW + 1, 1'b0, 1'b0, -1);
    rand_img(2);
    do_load(2, 1'b1, 1'b0, -1);
    rand_img(MAXW);
    do_load(MAXW, 1'b0, 1'b0, -1);

    rand_img(3);
    do_load(3, 1'b0, 1'b0, BPW + 2);
    repeat (4) @(negedge clk);
    do_load(3, 1'b1, 1'b0, -1);

    rand_img(4);
    do_load(4, 1'b0, 1'b1, -1);
    rand_img(2);
    do_load(2, 1'b0, 1'b0, -1);

    repeat (5) @(negedge clk);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
